sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 5, SRAM access cycles per transfer (valid range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  memory-stage write request.
REQ-006 SHALL have port rd_en  input  1  memory-stage read request.
REQ-007 SHALL have port address  input  32  byte address of the request.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  registered read data.
REQ-010 SHALL have port ready  output  1  high means no transfer is pending and the pipeline may advance; low means freeze the pipeline.
REQ-011 SHALL have port SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-012 SHALL have port SRAM_ADDR  output  17  SRAM word address.
REQ-013 SHALL have port SRAM_DQ  inout  32  SRAM bidirectional data bus.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE, plus a wait counter at least 4 bits wide.
REQ-015 In IDLE with wr_en=1 or rd_en=1, SHALL latch address, wdata and op type; wr_en wins if both are high; SHALL clear the counter and go to ACCESS.
REQ-016 In IDLE with neither request, SHALL stay in IDLE.
REQ-017 SRAM_ADDR SHALL be registered ((latched address - BASE_ADDR) >> 2)[16:0], using unsigned modulo subtraction; address bits [1:0] are ignored.
REQ-018 In ACCESS, the counter SHALL increment each cycle; on the cycle the counter equals WAIT_CYCLES-1, SHALL go to DONE, so ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-019 For a write, SRAM_WE_N SHALL be 0 for every ACCESS cycle and 1 in all other states and cycles.
REQ-020 For a write, SRAM_DQ SHALL be driven with the latched wdata during ACCESS only; otherwise it SHALL be high-Z (32'bz).
REQ-021 For a read, SHALL capture SRAM_DQ into rdata on the last ACCESS edge (counter = WAIT_CYCLES-1).
REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL not alter rdata.
REQ-023 DONE SHALL last one cycle, then go to IDLE.
REQ-024 ready SHALL be combinational:
- 1 in DONE;
- 1 in IDLE with no request;
- 0 in IDLE with a request;
- 0 in ACCESS.
REQ-025 Latency: a request sampled in IDLE at cycle 0 SHALL give ready=0 for cycles 0..WAIT_CYCLES and ready=1 in cycle WAIT_CYCLES+1 (DONE).
REQ-026 A request still asserted when IDLE is re-entered SHALL start a new transfer; the requester is responsible for deasserting or changing the request after the ready pulse.
REQ-027 wr_en, rd_en, address and wdata changes during ACCESS or DONE SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge, from any state including mid-ACCESS, SHALL set:
- state to IDLE;
- counter to 0;
- SRAM_WE_N to 1;
- SRAM_ADDR to 0;
- rdata to 0;
- SRAM_DQ to high-Z.
REQ-029 After reset with no request, ready SHALL be 1.
REQ-030 rst SHALL take priority over any request sampled on the same edge.

Verification (WAIT_CYCLES=5, BASE_ADDR=1024, SRAM model with 30 ns read delay)
REQ-031 Write wr_en=1, address=1024, wdata=0xDEADBEEF -> SRAM_ADDR=0, SRAM_WE_N=0 for exactly 5 cycles, DQ=0xDEADBEEF, ready=1 at cycle 6, SRAM word 0 = 0xDEADBEEF.
REQ-032 Read rd_en=1, address=1024 after REQ-031 -> SRAM_WE_N stays 1, DQ not driven by the controller, rdata=0xDEADBEEF in DONE, ready=0 for cycles 0..5.
REQ-033 Write address=1028 and 1031, data 0x11 then 0x22 -> both target SRAM_ADDR=1; a subsequent read of 1028 returns 0x22.
REQ-034 wr_en=1 and rd_en=1 together, address=1036, wdata=0x55 -> write performed to SRAM_ADDR=3; rdata unchanged.
REQ-035 rst asserted on the 3rd ACCESS cycle of a write -> next edge gives IDLE, SRAM_WE_N=1, DQ=Z, rdata=0, ready=1 with requests low.
REQ-036 No requests for 10 cycles after reset -> ready=1, SRAM_WE_N=1, DQ=Z throughout.

Source files
------------

// File: rtl/sram_ctrl.sv
// Memory-stage controller for an asynchronous 32-bit SRAM: each read or write
// holds the bus for WAIT_CYCLES cycles and stalls the pipeline via ready.
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [31:0] SRAM_DQ
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [31:0] offset;
  logic [14:0] unused_offset_bits;
  logic        request;

  // Word index wraps modulo 2^32 before the byte bits are dropped.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = {offset[31:19], offset[1:0]};
  assign request            = wr_en | rd_en;

  assign SRAM_DQ = (state_reg == ACCESS && write_reg) ? wdata_reg : 32'bz;

  always_comb begin
    ready = 1'b0;
    case (state_reg)
      IDLE:    ready = ~request;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      write_reg <= 1'b0;
      wdata_reg <= 32'd0;
      SRAM_WE_N <= 1'b1;
      SRAM_ADDR <= 17'd0;
      rdata     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            write_reg <= wr_en;
            wdata_reg <= wdata;
            SRAM_ADDR <= offset[18:2];
            SRAM_WE_N <= ~wr_en;
            cnt_reg   <= 4'd0;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            // Read data has had the full access window to settle on the bus.
            if (!write_reg) rdata <= SRAM_DQ;
            SRAM_WE_N <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
